// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight,
// buffers returned words in a small FIFO and presents the head to IF/ID.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | request at pc_q outstanding, push on response
// HOLD  | buffer full, waiting for a pop before requesting again
// DRAIN | abandoned request still open, its response is dropped
module fetch_unit #(
    parameter int            n        = 32,
    parameter logic [n-1:0]  RESET_PC = 32'h00000000,
    parameter int            DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [n-1:0] branch_target,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_valid,
    input  logic [n-1:0] imem_rdata,
    output logic [n-1:0] instruction_next,
    output logic [n-1:0] pc_next,
    output logic [n-1:0] pc_plus_four_next,
    output logic         fetch_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [n-1:0] NOP      = n'(32'h00000013);
    localparam logic [n-1:0] ALIGN    = ~n'(3);
    localparam logic [n-1:0] PC_INIT  = RESET_PC & ALIGN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state, state_d;
    logic [n-1:0]  pc_q;
    logic [n-1:0]  drain_addr;
    logic [n-1:0]  target_aligned;
    logic [n-1:0]  fifo_pc    [DEPTH];
    logic [n-1:0]  fifo_instr [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_after;
    logic          empty, push, pop;
    logic [n-1:0]  head_pc;

    assign target_aligned = branch_target & ALIGN;
    assign empty = (count == '0);
    assign push  = (state == S_REQ) && imem_valid && !branch_taken;
    assign pop   = !stall && !empty && !branch_taken;

    always_comb begin
        count_after = count;
        if (push) count_after = count_after + (AW + 1)'(1);
        if (pop)  count_after = count_after - (AW + 1)'(1);
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (branch_taken)
                    state_d = imem_valid ? S_REQ : S_DRAIN;
                else if (imem_valid)
                    state_d = (count_after < DEPTH_C) ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (branch_taken || (count < DEPTH_C))
                    state_d = S_REQ;
            end
            S_DRAIN: begin
                // A redirect while draining only retargets pc_q; the open
                // request still has to complete before a new one goes out.
                if (!branch_taken && imem_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc_q       <= PC_INIT;
            drain_addr <= PC_INIT;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_d;
            if (branch_taken) begin
                pc_q   <= target_aligned;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if ((state == S_REQ) && !imem_valid)
                    drain_addr <= pc_q;
            end else begin
                if (push) begin
                    pc_q   <= pc_q + n'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_q;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc_q;

    assign head_pc           = empty ? pc_q : fifo_pc[rd_ptr];
    assign pc_next           = head_pc;
    assign pc_plus_four_next = head_pc + n'(4);
    assign instruction_next  = empty ? NOP : fifo_instr[rd_ptr];
    assign fetch_valid       = !empty;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter, issues requests to instruction memory and buffers returned words in a small FIFO.
- Presents instruction_next / pc_next / pc_plus_four_next to IF/ID.
- Handles branch redirects (flush, discard in-flight response) and hazard stalls.

Parameters:
n, 32, datapath/address width
RESET_PC, 32'h00000000, PC value loaded on reset
DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold current output instruction, no pop
branch_taken  input  1  redirect request from execute
branch_target  input  n  redirect address
imem_req  output  1  instruction memory request
imem_addr  output  n  request address, word aligned
imem_valid  input  1  response valid
imem_rdata  input  n  response instruction word
instruction_next  output  n  to IF/ID
pc_next  output  n  to IF/ID
pc_plus_four_next  output  n  to IF/ID
fetch_valid  output  1  buffer head holds a real instruction

Behaviour:
- Reset (async, active-high): pc_q=RESET_PC, FIFO empty, state=IDLE, imem_req=0.
- Reset outputs: instruction_next=32'h00000013 (NOP), pc_next=0, pc_plus_four_next=4, fetch_valid=0.
- Memory handshake:
  - imem_req and imem_addr are held stable until imem_valid is sampled high.
  - imem_valid may be high in the same cycle as the first imem_req cycle (zero-wait memory).
  - At most one request is outstanding.
  - imem_addr[1:0] is always 0.
- FSM states: IDLE, REQ, HOLD, DRAIN.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc_q.
    - On imem_valid without redirect: push {pc_q, imem_rdata}; pc_q+=4.
    - After the push: stay in REQ if count_after<DEPTH, else HOLD.
  - HOLD: imem_req=0. Go to REQ when count<DEPTH, i.e. the cycle after a pop.
  - DRAIN: imem_req=1 with the abandoned address held. On imem_valid the data is discarded; then REQ.
- Redirect (branch_taken=1) takes priority over every other event in the same cycle:
  - pc_q <= {branch_target[n-1:2], 2'b00}; FIFO flushed at the next edge.
  - From REQ with imem_valid=0: go to DRAIN.
  - From REQ with imem_valid=1: response discarded, go to REQ.
  - From HOLD or IDLE: go to REQ.
  - In DRAIN: pc_q is updated, state stays DRAIN.
- Output path (combinational from the FIFO head):
  - When not empty: instruction_next=head.instr, pc_next=head.pc, pc_plus_four_next=head.pc+4 (mod 2^n), fetch_valid=1.
  - When empty: instruction_next=NOP 32'h00000013, pc_next=pc_q, pc_plus_four_next=pc_q+4, fetch_valid=0.
  - During the redirect cycle the outputs are unchanged; IF/ID applies its own branch NOP.
- Pop: at the clock edge when !stall && !empty && !branch_taken.
- Push and pop in the same cycle: count unchanged, order preserved.
- stall=1: head held; outputs stable each cycle so IF/ID reloads the same values. Fetching continues until the FIFO is full.
- Full: no push is possible because REQ is never entered with count==DEPTH.
- Empty: NOP bubbles, fetch_valid=0.
- Wrap-around: pc_q+4 at 32'hFFFFFFFC yields 0. FIFO pointers wrap modulo DEPTH.
- Reset mid-request: all state is cleared. The response to the abandoned request must not be captured after reset release; the memory side is also reset.

Test Plan:
1. Zero-wait memory, imem_valid tied to imem_req, no stall: after reset release, imem_addr goes 0,4,8,C on consecutive cycles. pc_next follows 0,4,8 one cycle behind, with instruction_next equal to the memory words.
2. 2-cycle memory latency: each address is held for 2 cycles. fetch_valid toggles 0/1 and a NOP (0x13) is presented on empty cycles.
3. stall=1 for 4 cycles at pc_next=8:
   - outputs hold 8/word8/C throughout;
   - imem_req drops once count=2 (HOLD);
   - after release, pc_next goes 8, C, 10 with no instruction lost.
4. branch_taken with target 0x103, issued while a request to 0x10 is in flight with 3-cycle latency:
   - DRAIN discards word 0x10 and the FIFO is flushed;
   - the next request has imem_addr=0x100;
   - the first valid pc_next is 0x100.
5. branch_taken coincident with imem_valid and a FIFO pop: response discarded, FIFO empty next cycle, next request at the target.
6. Assert reset mid-DRAIN: outputs immediately show NOP/fetch_valid=0 and pc_q=RESET_PC. After release, IDLE for one cycle, then imem_addr=RESET_PC.
